// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
//   Run/step/break controller for a CPU pipeline. It gates the pipeline
//   clock enable, stops on two address breakpoints or on an EBREAK reaching
//   WB, executes host commands and counts enabled cycles.
//
// Ports
//   cpu_clk    in   clock
//   cpu_rstn   in   asynchronous active-low reset
//   cmd_valid  in   command strobe, sampled every cycle (no back-pressure)
//   cmd_op     in   3  0 NOP,1 RUN,2 STEP,3 PAUSE,4 SET_BP0,5 SET_BP1,6 CLR_BP,7 CLR_CNT
//   cmd_data   in   32 breakpoint address (SET_BP0/1), step count in [15:0] (STEP)
//   pc         in   32 current fetch PC
//   ir_wb      in   32 instruction in WB
//   cpu_en     out  pipeline clock enable (combinational)
//   state      out  2  0 IDLE,1 RUN,2 STEP,3 BREAK
//   brk_cause  out  2  0 none,1 BP0,2 BP1,3 EBREAK
//   cycle_cnt  out  32 count of cycles with cpu_en=1 (wraps)
//   cmd_ack    out  registered pulse: command executed
//   cmd_err    out  registered pulse: command rejected
module pipeline_run_ctrl (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  input  logic [31:0] pc,
  input  logic [31:0] ir_wb,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [1:0]  brk_cause,
  output logic [31:0] cycle_cnt,
  output logic        cmd_ack,
  output logic        cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  localparam logic [2:0]  OP_RUN     = 3'd1;
  localparam logic [2:0]  OP_STEP    = 3'd2;
  localparam logic [2:0]  OP_PAUSE   = 3'd3;
  localparam logic [2:0]  OP_SET_BP0 = 3'd4;
  localparam logic [2:0]  OP_SET_BP1 = 3'd5;
  localparam logic [2:0]  OP_CLR_BP  = 3'd6;
  localparam logic [2:0]  OP_CLR_CNT = 3'd7;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  state_t      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] step_q, step_d;
  logic        skip_q, skip_d;
  logic        ack_d, err_d;
  logic [31:0] bp0_q, bp1_q;
  logic        bp0_en_q, bp1_en_q;
  logic [31:0] cnt_q;

  logic running, bp0_hit, bp1_hit, bp_match, ebreak_hit, brk_evt;
  logic is_run, is_step, is_pause, resume_ok;

  assign running    = (state_q == S_RUN) || (state_q == S_STEP);
  assign bp0_hit    = bp0_en_q && (pc == bp0_q);
  assign bp1_hit    = bp1_en_q && (pc == bp1_q);
  // skip masks the breakpoint for the first enabled cycle after a resume so
  // the instruction we stopped on actually executes.
  assign bp_match   = !skip_q && (bp0_hit || bp1_hit);
  assign cpu_en     = running && !bp_match;
  assign ebreak_hit = cpu_en && (ir_wb == EBREAK_INSN);
  assign brk_evt    = (running && bp_match) || ebreak_hit;

  assign is_run    = cmd_valid && (cmd_op == OP_RUN);
  assign is_step   = cmd_valid && (cmd_op == OP_STEP);
  assign is_pause  = cmd_valid && (cmd_op == OP_PAUSE);
  assign resume_ok = (state_q == S_IDLE) || (state_q == S_BREAK);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    step_d  = step_q;
    skip_d  = skip_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    if (cpu_en) begin
      skip_d = 1'b0;
      if (state_q == S_STEP) step_d = step_q - 16'd1;
    end

    // A break event outranks any same-cycle run-control command.
    if (brk_evt) begin
      state_d = S_BREAK;
      cause_d = bp_match ? (bp0_hit ? 2'd1 : 2'd2) : 2'd3;
    end else if (is_run && resume_ok) begin
      state_d = S_RUN;
      skip_d  = 1'b1;
      cause_d = 2'd0;
    end else if (is_step && resume_ok) begin
      state_d = S_STEP;
      step_d  = (cmd_data[15:0] == 16'd0) ? 16'd1 : cmd_data[15:0];
      skip_d  = 1'b1;
      cause_d = 2'd0;
    end else if (is_pause && running) begin
      state_d = S_IDLE;
    end else if ((state_q == S_STEP) && cpu_en && (step_q == 16'd1)) begin
      state_d = S_IDLE;
    end

    if (cmd_valid) begin
      unique case (cmd_op)
        OP_RUN, OP_STEP: begin
          if (resume_ok && !brk_evt) ack_d = 1'b1;
          else                       err_d = 1'b1;
        end
        OP_PAUSE: begin
          if (running && !brk_evt) ack_d = 1'b1;
          else                     err_d = 1'b1;
        end
        OP_SET_BP0, OP_SET_BP1, OP_CLR_BP, OP_CLR_CNT: ack_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= S_IDLE;
      cause_q <= 2'd0;
      step_q  <= 16'd0;
      skip_q  <= 1'b0;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      step_q  <= step_d;
      skip_q  <= skip_d;
      cmd_ack <= ack_d;
      cmd_err <= err_d;
    end
  end

  // Breakpoint registers: CLR_BP drops the enables but keeps the addresses.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      bp0_q    <= 32'd0;
      bp1_q    <= 32'd0;
      bp0_en_q <= 1'b0;
      bp1_en_q <= 1'b0;
    end else if (cmd_valid) begin
      if (cmd_op == OP_SET_BP0) begin
        bp0_q    <= cmd_data;
        bp0_en_q <= 1'b1;
      end
      if (cmd_op == OP_SET_BP1) begin
        bp1_q    <= cmd_data;
        bp1_en_q <= 1'b1;
      end
      if (cmd_op == OP_CLR_BP) begin
        bp0_en_q <= 1'b0;
        bp1_en_q <= 1'b0;
      end
    end
  end

  // CLR_CNT wins over the increment of the same cycle; the counter wraps.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)                             cnt_q <= 32'd0;
    else if (cmd_valid && cmd_op == OP_CLR_CNT) cnt_q <= 32'd0;
    else if (cpu_en)                           cnt_q <= cnt_q + 32'd1;
  end

  assign state     = state_q;
  assign brk_cause = cause_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
module tb_pipeline_run_ctrl;

  localparam logic [2:0]  NOP = 3'd0, RUN = 3'd1, STEP = 3'd2, PAUSE = 3'd3,
                          SBP0 = 3'd4, SBP1 = 3'd5, CBP = 3'd6, CCNT = 3'd7;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] INOP = 32'h0000_0013;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = NOP;
  logic [31:0] cmd_data = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] ir_wb = INOP;
  logic        cpu_en, cmd_ack, cmd_err;
  logic [1:0]  state, brk_cause;
  logic [31:0] cycle_cnt;

  pipeline_run_ctrl dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pc(pc), .ir_wb(ir_wb),
    .cpu_en(cpu_en), .state(state), .brk_cause(brk_cause),
    .cycle_cnt(cycle_cnt), .cmd_ack(cmd_ack), .cmd_err(cmd_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be after the upcoming edge.
  int          m_state;      // 0 IDLE 1 RUN 2 STEP 3 BREAK
  int          m_cause;
  int          m_left;
  bit          m_skip;
  logic [31:0] m_bp0, m_bp1;
  bit          m_bp0_on, m_bp1_on;
  logic [31:0] m_cnt;
  bit          m_ack, m_err;
  int          en_seen, ack_seen, err_seen;

  always @(negedge cpu_clk) begin
    bit run_st, hit0, hit1, hit, en, brk, ctl, legal;
    #2;
    if (!cpu_rstn) begin
      m_state = 0; m_cause = 0; m_left = 0; m_skip = 0;
      m_bp0 = 0; m_bp1 = 0; m_bp0_on = 0; m_bp1_on = 0;
      m_cnt = 0; m_ack = 0; m_err = 0;
    end
    chk("state", 32'(state), 32'(m_state));
    chk("brk_cause", 32'(brk_cause), 32'(m_cause));
    chk("cycle_cnt", cycle_cnt, m_cnt);
    chk("cmd_ack", 32'(cmd_ack), 32'(m_ack));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));

    run_st = (m_state == 1) || (m_state == 2);
    hit0 = m_bp0_on && (pc == m_bp0);
    hit1 = m_bp1_on && (pc == m_bp1);
    hit  = !m_skip && (hit0 || hit1);
    en   = cpu_rstn && run_st && !hit;
    chk("cpu_en", 32'(cpu_en), 32'(en));

    if (cpu_en)  en_seen++;
    if (cmd_ack) ack_seen++;
    if (cmd_err) err_seen++;

    if (cpu_rstn) begin
      brk   = (run_st && hit) || (en && ir_wb == EBRK);
      ctl   = cmd_valid && (cmd_op == RUN || cmd_op == STEP || cmd_op == PAUSE);
      legal = (cmd_op == PAUSE) ? run_st : (m_state == 0 || m_state == 3);
      m_ack = cmd_valid && ((ctl && legal && !brk) || cmd_op >= SBP0);
      m_err = ctl && (!legal || brk);

      if (cmd_valid && cmd_op == CCNT) m_cnt = 0;
      else if (en)                     m_cnt = m_cnt + 1;

      if (cmd_valid && cmd_op == SBP0) begin m_bp0 = cmd_data; m_bp0_on = 1; end
      if (cmd_valid && cmd_op == SBP1) begin m_bp1 = cmd_data; m_bp1_on = 1; end
      if (cmd_valid && cmd_op == CBP)  begin m_bp0_on = 0; m_bp1_on = 0; end

      if (brk) begin
        m_cause = hit ? (hit0 ? 1 : 2) : 3;
        m_state = 3;
      end else if (ctl && legal && cmd_op == RUN) begin
        m_state = 1; m_skip = 1; m_cause = 0;
      end else if (ctl && legal && cmd_op == STEP) begin
        m_state = 2; m_skip = 1; m_cause = 0;
        m_left  = (cmd_data[15:0] == 0) ? 1 : int'(cmd_data[15:0]);
      end else if (ctl && legal && cmd_op == PAUSE) begin
        m_state = 0;
      end else if (m_state == 2 && en) begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end
      if (en && !(ctl && legal && !brk && cmd_op != PAUSE)) m_skip = 0;
    end
  end

  logic rst_nx = 1'b0;
  logic [31:0] ir_nx = INOP;

  task automatic cyc(input bit v, input logic [2:0] op, input logic [31:0] d,
                     input logic [31:0] p);
    @(negedge cpu_clk);
    cpu_rstn  = rst_nx;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    pc        = p;
    ir_wb     = ir_nx;
    #3;
  endtask

  task automatic clr_seen();
    en_seen = 0; ack_seen = 0; err_seen = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr_seen();
    // Reset state
    cyc(0, NOP, 0, 0);
    cyc(0, NOP, 0, 0);
    chk("rst state", 32'(state), 0);
    chk("rst cnt", cycle_cnt, 0);
    chk("rst en", 32'(cpu_en), 0);
    chk("rst ack", 32'(cmd_ack), 0);
    chk("rst err", 32'(cmd_err), 0);
    rst_nx = 1'b1;
    cyc(0, NOP, 0, 0);

    // STEP 3 from IDLE
    clr_seen();
    cyc(1, STEP, 3, 0);
    for (int i = 0; i < 5; i++) cyc(0, NOP, 0, 32'(4 * i));
    chk("step3 en cycles", 32'(en_seen), 3);
    chk("step3 cnt", cycle_cnt, 3);
    chk("step3 state", 32'(state), 0);
    chk("step3 ack pulses", 32'(ack_seen), 1);

    // Breakpoint 0 at 0x10, then resume over it
    cyc(1, SBP0, 32'h10, 0);
    cyc(1, RUN, 0, 0);
    cyc(0, NOP, 0, 32'h0);
    cyc(0, NOP, 0, 32'h4);
    cyc(0, NOP, 0, 32'h8);
    cyc(0, NOP, 0, 32'hC);
    cyc(0, NOP, 0, 32'h10);
    chk("bp0 en at 0x10", 32'(cpu_en), 0);
    cyc(0, NOP, 0, 32'h10);
    chk("bp0 state", 32'(state), 3);
    chk("bp0 cause", 32'(brk_cause), 1);
    chk("bp0 en in break", 32'(cpu_en), 0);
    cyc(1, RUN, 0, 32'h10);
    cyc(0, NOP, 0, 32'h10);
    chk("resume en skip", 32'(cpu_en), 1);
    chk("resume cause", 32'(brk_cause), 0);
    cyc(0, NOP, 0, 32'h14);
    cyc(1, PAUSE, 0, 32'h18);
    chk("pause en acc cycle", 32'(cpu_en), 1);
    cyc(0, NOP, 0, 32'h1C);
    chk("pause en after", 32'(cpu_en), 0);
    cyc(1, CBP, 0, 32'h1C);

    // EBREAK reaching WB
    cyc(1, RUN, 0, 32'h100);
    cyc(0, NOP, 0, 32'h104);
    ir_nx = EBRK;
    cyc(0, NOP, 0, 32'h108);
    ir_nx = INOP;
    cyc(0, NOP, 0, 32'h10C);
    chk("ebrk state", 32'(state), 3);
    chk("ebrk cause", 32'(brk_cause), 3);
    chk("ebrk en", 32'(cpu_en), 0);

    // Illegal commands
    cyc(1, STEP, 1, 32'h10C);
    cyc(0, NOP, 0, 32'h10C);
    cyc(0, NOP, 0, 32'h110);
    cyc(1, PAUSE, 0, 32'h110);
    cyc(0, NOP, 0, 32'h110);
    chk("pause idle err", 32'(cmd_err), 1);
    chk("pause idle state", 32'(state), 0);
    cyc(1, RUN, 0, 32'h110);
    cyc(1, RUN, 0, 32'h114);
    cyc(0, NOP, 0, 32'h118);
    chk("run run err", 32'(cmd_err), 1);
    chk("run run state", 32'(state), 1);
    cyc(1, PAUSE, 0, 32'h11C);
    cyc(0, NOP, 0, 32'h120);

    // PAUSE colliding with a BP1 match
    cyc(1, SBP1, 32'h200, 32'h1F0);
    cyc(1, RUN, 0, 32'h1F4);
    cyc(0, NOP, 0, 32'h1F8);
    cyc(0, NOP, 0, 32'h1FC);
    cyc(1, PAUSE, 0, 32'h200);
    cyc(0, NOP, 0, 32'h200);
    chk("bp1 pause state", 32'(state), 3);
    chk("bp1 pause cause", 32'(brk_cause), 2);
    chk("bp1 pause err", 32'(cmd_err), 1);
    chk("bp1 pause ack", 32'(cmd_ack), 0);

    // Both breakpoints on one address: BP0 wins
    cyc(1, SBP0, 32'h200, 32'h200);
    cyc(1, RUN, 0, 32'h200);
    cyc(0, NOP, 0, 32'h200);
    cyc(0, NOP, 0, 32'h204);
    cyc(0, NOP, 0, 32'h200);
    cyc(0, NOP, 0, 32'h200);
    chk("both bp cause", 32'(brk_cause), 1);

    // STEP 0 acts as STEP 1
    cyc(1, CBP, 0, 32'h200);
    clr_seen();
    cyc(1, STEP, 32'hABCD_0000, 32'h200);
    cyc(0, NOP, 0, 32'h204);
    cyc(0, NOP, 0, 32'h208);
    cyc(0, NOP, 0, 32'h208);
    chk("step0 en cycles", 32'(en_seen), 1);

    // Counter wrap
    cyc(0, NOP, 0, 32'h208);
    force dut.cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    cyc(1, STEP, 1, 32'h208);
    cyc(0, NOP, 0, 32'h208);
    cyc(0, NOP, 0, 32'h20C);
    chk("cnt wrap", cycle_cnt, 0);

    // CLR_CNT overrides same-cycle increment
    cyc(1, RUN, 0, 32'h300);
    cyc(0, NOP, 0, 32'h304);
    cyc(0, NOP, 0, 32'h308);
    cyc(1, CCNT, 0, 32'h30C);
    cyc(0, NOP, 0, 32'h310);
    chk("clr cnt", cycle_cnt, 0);
    cyc(1, PAUSE, 0, 32'h314);
    cyc(0, NOP, 0, 32'h318);

    // Reset in the middle of STEP with 5 left
    cyc(1, STEP, 10, 32'h400);
    for (int i = 0; i < 5; i++) cyc(0, NOP, 0, 32'(32'h400 + 4 * i));
    rst_nx = 1'b0;
    cyc(0, NOP, 0, 32'h414);
    chk("midrst state", 32'(state), 0);
    chk("midrst cnt", cycle_cnt, 0);
    chk("midrst en", 32'(cpu_en), 0);
    chk("midrst cause", 32'(brk_cause), 0);
    cyc(0, NOP, 0, 32'h414);
    rst_nx = 1'b1;
    clr_seen();
    for (int i = 0; i < 6; i++) cyc(0, NOP, 0, 32'h414);
    chk("midrst en after", 32'(en_seen), 0);
    chk("midrst state after", 32'(state), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
PIPELINE_RUN_CTRL -- requirements
Module: pipeline_run_ctrl

Interface
REQ-001 SHALL have port cpu_clk, input, 1: clock.
REQ-002 SHALL have port cpu_rstn, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port cmd_valid, input, 1: command strobe, sampled every cycle; no back-pressure.
REQ-004 SHALL have port cmd_op, input, 3: 0 NOP, 1 RUN, 2 STEP, 3 PAUSE, 4 SET_BP0, 5 SET_BP1, 6 CLR_BP, 7 CLR_CNT.
REQ-005 SHALL have port cmd_data, input, 32: breakpoint address for SET_BP0/1; step count in bits [15:0] for STEP.
REQ-006 SHALL have port pc, input, 32: current fetch PC of the pipeline.
REQ-007 SHALL have port ir_wb, input, 32: instruction in the WB stage.
REQ-008 SHALL have port cpu_en, output, 1: pipeline clock enable, combinational.
REQ-009 SHALL have port state, output, 2: 0 IDLE, 1 RUN, 2 STEP, 3 BREAK.
REQ-010 SHALL have port brk_cause, output, 2: 0 none, 1 BP0, 2 BP1, 3 EBREAK.
REQ-011 SHALL have port cycle_cnt, output, 32: number of cycles with cpu_en=1.
REQ-012 SHALL have port cmd_ack, output, 1: registered one-cycle pulse, legal command executed.
REQ-013 SHALL have port cmd_err, output, 1: registered one-cycle pulse, command rejected.

Function
REQ-014 SHALL implement the FSM IDLE, RUN, STEP and BREAK.
REQ-015 SHALL compute cpu_en = (state==RUN or STEP) and not bp_match.
REQ-016 SHALL define bp_match = not skip and ((bp0_en and pc==bp0) or (bp1_en and pc==bp1)).
REQ-017 SHALL, on a bp_match cycle, move to BREAK on the next edge with brk_cause 1 if BP0 matches, else 2; BP0 wins when both match.
REQ-018 SHALL, when cpu_en=1 and ir_wb==32'h00100073, move to BREAK on the next edge with brk_cause=3.
REQ-019 SHALL accept RUN only in IDLE or BREAK; next state RUN; skip set.
REQ-020 SHALL accept STEP only in IDLE or BREAK; step_left=cmd_data[15:0], with 0 treated as 1; next state STEP; skip set.
REQ-021 SHALL set skip only on RUN/STEP acceptance and clear it after the first cpu_en=1 cycle, so a resume executes the breakpointed instruction.
REQ-022 SHALL, in STEP, decrement step_left on every cpu_en=1 cycle; with step_left==1 and cpu_en=1, go to IDLE next edge; cpu_en is high for exactly N cycles unless a break intervenes.
REQ-023 SHALL accept PAUSE only in RUN or STEP; next state IDLE; cpu_en stays high in the acceptance cycle and drops the following cycle.
REQ-024 SHALL accept SET_BP0/SET_BP1 in any state: load the address, set the enable, effective from the next cycle.
REQ-025 SHALL accept CLR_BP in any state: clear both enables; addresses retained.
REQ-026 SHALL accept CLR_CNT in any state: cycle_cnt=0 next edge, overriding that cycle's increment.
REQ-027 SHALL accept NOP in any state; NOP produces no ack and no err.
REQ-028 SHALL pulse cmd_err one cycle after a RUN, STEP or PAUSE issued in an illegal state; state is unchanged.
REQ-029 SHALL give a break event (REQ-017/018) priority over a same-cycle RUN/STEP/PAUSE: BREAK is entered and cmd_err pulses; same-cycle SET_BP/CLR_BP/CLR_CNT still execute and ack.
REQ-030 SHALL keep brk_cause until the next RUN/STEP acceptance, which clears it to 0.
REQ-031 SHALL increment cycle_cnt modulo 2^32 (0xFFFFFFFF -> 0).

Reset
REQ-032 SHALL, on cpu_rstn low, immediately set state=IDLE, cpu_en=0, brk_cause=0, cycle_cnt=0, step_left=0, skip=0, bp0=bp1=0, both enables 0, cmd_ack=cmd_err=0.
REQ-033 SHALL abort any RUN/STEP on reset mid-operation with no further cpu_en pulses; operation resumes only on a new command after release.

Verification
REQ-034 SHALL check: STEP with cmd_data=3 from IDLE -> cpu_en high exactly 3 cycles, cycle_cnt=3, state IDLE, cmd_ack one pulse.
REQ-035 SHALL check: SET_BP0 with cmd_data=0x10, RUN, pc advancing 0,4,8,C,10 -> cpu_en low at pc=0x10, state BREAK, brk_cause=1; a following RUN -> cpu_en high at pc=0x10 (skip), brk_cause=0.
REQ-036 SHALL check: ir_wb=0x00100073 while RUN -> state BREAK next edge, brk_cause=3, cpu_en=0.
REQ-037 SHALL check: PAUSE in IDLE -> cmd_err pulse, state IDLE; RUN in RUN -> cmd_err pulse, state RUN.
REQ-038 SHALL check: PAUSE issued in the same cycle as a BP1 match -> state BREAK, brk_cause=2, cmd_err pulse.
REQ-039 SHALL check: cycle_cnt forced to 0xFFFFFFFF, one enabled cycle -> 0; assert cpu_rstn mid-STEP with 5 left -> all outputs reset, no cpu_en after release.
